// File: rtl/tdp_ram_pkg.sv
// Shared types for the byte-enabled true-dual-port RAM:
// write-mode encodings, sequencer states and a width helper.
package tdp_ram_pkg;

    // What a port's output register does when that port writes.
    typedef enum logic [1:0] {
        NO_CHANGE   = 2'd0,
        READ_FIRST  = 2'd1,
        WRITE_FIRST = 2'd2
    } write_mode_e;

    // Zero-fill sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Address width for a given depth; never returns less than 1 bit.
    function automatic int clog2(input int value);
        int result = 0;
        int v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/tdp_ram_be_if.sv
// Two-port RAM bus: request/response signals for ports A and B plus the
// shared status outputs. The RAM uses the slave view.
interface tdp_ram_be_if #(
    parameter int NUM_COL = 4,
    parameter int COL_W   = 8,
    parameter int ADDR_W  = 10
);
    logic                       ena;
    logic [NUM_COL-1:0]         wea;
    logic [ADDR_W-1:0]          addra;
    logic [NUM_COL*COL_W-1:0]   dina;
    logic [NUM_COL*COL_W-1:0]   douta;
    logic                       douta_vld;

    logic                       enb;
    logic [NUM_COL-1:0]         web;
    logic [ADDR_W-1:0]          addrb;
    logic [NUM_COL*COL_W-1:0]   dinb;
    logic [NUM_COL*COL_W-1:0]   doutb;
    logic                       doutb_vld;

    logic                       clr_busy;
    logic                       collision;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, douta_vld, doutb, doutb_vld, clr_busy, collision
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, douta_vld, doutb, doutb_vld, clr_busy, collision
    );
endinterface

// File: rtl/tdp_ram_outstage.sv
// Per-port output pipeline: delays the read word and its valid strobe by
// RD_LATENCY (1 or 2) cycles. The output word only changes when 'load' was
// set on entry, so it holds across cycles with nothing to report.
module tdp_ram_outstage #(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld
);
    logic              stg_load;
    logic              stg_vld;
    logic [DATA_W-1:0] stg_data;

    generate
        if (RD_LATENCY == 2) begin : g_two
            // Extra register stage for the two-cycle configuration.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_load <= 1'b0;
                    stg_vld  <= 1'b0;
                    stg_data <= '0;
                end else begin
                    stg_load <= load;
                    stg_vld  <= vld_in;
                    if (load) stg_data <= din;
                end
            end
        end else begin : g_one
            assign stg_load = load;
            assign stg_vld  = vld_in;
            assign stg_data = din;
        end
    endgenerate

    // Final output register; the valid strobe is a single-cycle pulse.
    // NOTE: registered state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= stg_vld;
            if (stg_load) dout <= stg_data;
        end
    end
endmodule

// File: rtl/tdp_ram_be.sv
// True-dual-port RAM with per-column write enables, a post-reset zero-fill
// sequencer, selectable write-port output behaviour and same-address
// collision reporting. Single clock; port A wins column overlaps.
module tdp_ram_be
    import tdp_ram_pkg::*;
#(
    parameter int          NUM_COL        = 4,
    parameter int          COL_W          = 8,
    parameter int          DEPTH          = 1024,
    parameter int          RD_LATENCY     = 1,
    parameter write_mode_e WRITE_MODE     = NO_CHANGE,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clka,
    input  logic        rst_n,
    tdp_ram_be_if.slave bus
);
    localparam int                DATA_W    = NUM_COL * COL_W;
    localparam int                ADDR_W    = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e                state;
    logic                  clr_busy_q;
    logic [ADDR_W-1:0]     clr_addr;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
    logic                  same_addr, coll_now, load_a, load_b;
    logic [DATA_W-1:0]     old_a, old_b, new_a, new_b, data_a, data_b;
    logic [RD_LATENCY-1:0] coll_sr;

    // Requests are ignored entirely while the zero-fill runs.
    assign acc_a     = bus.ena & ~clr_busy_q;
    assign acc_b     = bus.enb & ~clr_busy_q;
    assign wr_a      = acc_a & (|bus.wea);
    assign wr_b      = acc_b & (|bus.web);
    assign rd_a      = acc_a & ~(|bus.wea);
    assign rd_b      = acc_b & ~(|bus.web);
    assign same_addr = (bus.addra == bus.addrb);
    assign coll_now  = acc_a & acc_b & same_addr & (wr_a | wr_b);

    // Merge both ports' column writes into the addressed words; A is applied
    // last so it owns any column both ports enable.
    // NOTE: every combinational output gets a default before conditional updates, so no latch is inferred.
    always_comb begin
        old_a = mem[bus.addra];
        old_b = mem[bus.addrb];
        new_a = old_a;
        new_b = old_b;
        for (int c = 0; c < NUM_COL; c++) begin
            if (wr_b && bus.web[c]) begin
                new_b[c*COL_W +: COL_W] = bus.dinb[c*COL_W +: COL_W];
                if (same_addr) new_a[c*COL_W +: COL_W] = bus.dinb[c*COL_W +: COL_W];
            end
        end
        for (int c = 0; c < NUM_COL; c++) begin
            if (wr_a && bus.wea[c]) begin
                new_a[c*COL_W +: COL_W] = bus.dina[c*COL_W +: COL_W];
                if (same_addr) new_b[c*COL_W +: COL_W] = bus.dina[c*COL_W +: COL_W];
            end
        end
    end

    // Clear sequencer: one zero word per cycle from address 0, then idle
    // in READY with the counter parked at the last address.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else                state <= READY;
            clr_busy_q <= CLEAR_ON_RESET;
            clr_addr   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state      <= READY;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: clr_busy_q <= 1'b0;
            endcase
        end
    end

    // Storage array: zero-fill while busy, otherwise the merged port words.
    // NOTE: the array has no reset branch; only the clear sequence zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clka) begin
        if (clr_busy_q) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_b) mem[bus.addrb] <= new_b;
            if (wr_a) mem[bus.addra] <= new_a;
        end
    end

    // Output-register source per port: reads always return the pre-write
    // word; writes load according to the configured write mode.
    assign load_a = rd_a | (wr_a & (WRITE_MODE != NO_CHANGE));
    assign load_b = rd_b | (wr_b & (WRITE_MODE != NO_CHANGE));
    assign data_a = (wr_a && WRITE_MODE == WRITE_FIRST) ? new_a : old_a;
    assign data_b = (wr_b && WRITE_MODE == WRITE_FIRST) ? new_b : old_b;

    // Collision flag travels alongside the data so both emerge together.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) coll_sr <= '0;
        else        coll_sr <= RD_LATENCY'({coll_sr, coll_now});
    end

    assign bus.collision = coll_sr[RD_LATENCY-1];
    assign bus.clr_busy  = clr_busy_q;

    tdp_ram_outstage #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_out_a (
        .clk      (clka),
        .rst_n    (rst_n),
        .load     (load_a),
        .vld_in   (rd_a),
        .din      (data_a),
        .dout     (bus.douta),
        .dout_vld (bus.douta_vld)
    );

    tdp_ram_outstage #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_out_b (
        .clk      (clka),
        .rst_n    (rst_n),
        .load     (load_b),
        .vld_in   (rd_b),
        .din      (data_b),
        .dout     (bus.doutb),
        .dout_vld (bus.doutb_vld)
    );
endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: three instances share one stimulus stream
// (lat1/NO_CHANGE, lat2/READ_FIRST, lat1/WRITE_FIRST, DEPTH=16).
// Expected read words and collision cycles are queued at issue time and
// popped by a monitor whenever a DUT raises a valid or collision pulse.
module tb_tdp_ram_be;
    import tdp_ram_pkg::*;

    localparam int ND = 3;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    logic        ena, enb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;

    logic [ND-1:0][31:0] douta_s, doutb_s;
    logic [ND-1:0]       vlda_s, vldb_s, busy_s, coll_s;

    exp_t qa [ND][$];
    exp_t qb [ND][$];
    int   qc [ND][$];

    int cyc;
    int n_tests;
    int n_fail;
    bit ready_m;

    function automatic int lat_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic write_mode_e mode_of(input int d);
        case (d)
            0:       return NO_CHANGE;
            1:       return READ_FIRST;
            default: return WRITE_FIRST;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tdp_ram_be_if #(.NUM_COL(4), .COL_W(8), .ADDR_W(4)) bus ();

        assign bus.ena   = ena;
        assign bus.wea   = wea;
        assign bus.addra = addra;
        assign bus.dina  = dina;
        assign bus.enb   = enb;
        assign bus.web   = web;
        assign bus.addrb = addrb;
        assign bus.dinb  = dinb;

        assign douta_s[g] = bus.douta;
        assign doutb_s[g] = bus.doutb;
        assign vlda_s[g]  = bus.douta_vld;
        assign vldb_s[g]  = bus.doutb_vld;
        assign busy_s[g]  = bus.clr_busy;
        assign coll_s[g]  = bus.collision;

        tdp_ram_be #(
            .NUM_COL        (4),
            .COL_W          (8),
            .DEPTH          (16),
            .RD_LATENCY     (lat_of(g)),
            .WRITE_MODE     (mode_of(g)),
            .CLEAR_ON_RESET (1'b1)
        ) u_dut (
            .clka  (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a DUT presents read data or a collision.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (vlda_s[d]) begin
                if (qa[d].size() == 0) check($sformatf("dut%0d douta_vld unexpected", d), 32'd1, 32'd0);
                else begin
                    e = qa[d].pop_front();
                    check($sformatf("dut%0d douta", d), douta_s[d], e.data);
                    check($sformatf("dut%0d douta cycle", d), cyc, e.due);
                end
            end
            if (vldb_s[d]) begin
                if (qb[d].size() == 0) check($sformatf("dut%0d doutb_vld unexpected", d), 32'd1, 32'd0);
                else begin
                    e = qb[d].pop_front();
                    check($sformatf("dut%0d doutb", d), doutb_s[d], e.data);
                    check($sformatf("dut%0d doutb cycle", d), cyc, e.due);
                end
            end
            if (coll_s[d]) begin
                if (qc[d].size() == 0) check($sformatf("dut%0d collision unexpected", d), 32'd1, 32'd0);
                else check($sformatf("dut%0d collision cycle", d), cyc, qc[d].pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        for (int d = 0; d < ND; d++) begin
            qa[d].delete();
            qb[d].delete();
            qc[d].delete();
        end
    endtask

    // One access cycle. For a write (we != 0) 'v' is the write data; for a
    // read it is the hand-computed word the read must return.
    task automatic drive(input bit ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] va,
                         input bit eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] vb,
                         input bit coll);
        ena   = ea;
        wea   = wa;
        addra = aa;
        dina  = (wa != 4'd0) ? va : 32'd0;
        enb   = eb;
        web   = wb;
        addrb = ab;
        dinb  = (wb != 4'd0) ? vb : 32'd0;
        if (ready_m) begin
            for (int d = 0; d < ND; d++) begin
                if (ea && wa == 4'd0) qa[d].push_back('{data: va, due: cyc + lat_of(d)});
                if (eb && wb == 4'd0) qb[d].push_back('{data: vb, due: cyc + lat_of(d)});
                if (coll)             qc[d].push_back(cyc + lat_of(d));
            end
        end
        tick();
        ena = 1'b0;
        enb = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s dut%0d douta", tag, d), douta_s[d], 32'd0);
            check($sformatf("%s dut%0d doutb", tag, d), doutb_s[d], 32'd0);
            check($sformatf("%s dut%0d douta_vld", tag, d), 32'(vlda_s[d]), 32'd0);
            check($sformatf("%s dut%0d doutb_vld", tag, d), 32'(vldb_s[d]), 32'd0);
            check($sformatf("%s dut%0d collision", tag, d), 32'(coll_s[d]), 32'd0);
            check($sformatf("%s dut%0d clr_busy", tag, d), 32'(busy_s[d]), 32'd1);
        end
    endtask

    // Counts clr_busy cycles after reset release (bounded). With 'poke' set,
    // a write to addr 0 and a read of addr 1 are attempted in the 16th busy
    // cycle; both must be dropped. Returns on the cycle clr_busy falls.
    task automatic clear_phase(input bit poke);
        int n [ND];
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < ND; d++) if (busy_s[d]) n[d]++;
            if (busy_s == '0) break;
            if (poke && n[0] == 16) begin
                ena = 1'b1; wea = 4'hF; addra = 4'd0; dina = 32'hDEADBEEF;
                enb = 1'b1; web = 4'h0; addrb = 4'd1; dinb = 32'd0;
            end
            tick();
            ena = 1'b0;
            enb = 1'b0;
        end
        for (int d = 0; d < ND; d++) check($sformatf("dut%0d clear cycles", d), n[d], 32'd16);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ready_m = 1'b0;
        rst_n = 1'b0;
        ena = 1'b0; wea = '0; addra = '0; dina = '0;
        enb = 1'b0; web = '0; addrb = '0; dinb = '0;

        repeat (3) @(posedge clk);
        #2;
        check_reset("por");
        rst_n = 1'b1;
        clear_phase(1'b0);
        ready_m = 1'b1;

        // Zero-fill readback, back-to-back, starting on the cycle clr_busy falls.
        for (int i = 0; i < 16; i++)
            drive(1, 4'h0, 4'(15 - i), 32'd0, 1, 4'h0, 4'(i), 32'd0, 0);

        // Column write merge.
        drive(1, 4'hF, 4'd5, 32'hAABBCCDD, 0, 4'h0, 4'd0, 32'd0, 0);
        drive(1, 4'h2, 4'd5, 32'h00001100, 0, 4'h0, 4'd0, 32'd0, 0);
        drive(0, 4'h0, 4'd0, 32'd0,        1, 4'h0, 4'd5, 32'hAABB11DD, 0);

        // Collisions: full/partial write-write, read-write, then readback.
        drive(1, 4'hF, 4'd3, 32'h11111111, 1, 4'h3, 4'd3, 32'h22222222, 1);
        drive(1, 4'h0, 4'd3, 32'h11111111, 1, 4'h0, 4'd3, 32'h11111111, 0);
        drive(1, 4'h1, 4'd4, 32'h000000AA, 1, 4'hE, 4'd4, 32'hBBBBBB00, 1);
        drive(1, 4'h0, 4'd4, 32'hBBBBBBAA, 0, 4'h0, 4'd0, 32'd0, 0);
        drive(1, 4'h0, 4'd5, 32'hAABB11DD, 1, 4'hF, 4'd5, 32'h12345678, 1);
        drive(1, 4'h0, 4'd5, 32'h12345678, 1, 4'h0, 4'd3, 32'h11111111, 0);
        drive(1, 4'hF, 4'd6, 32'h00000066, 1, 4'hF, 4'd9, 32'h00000099, 0);
        drive(1, 4'h0, 4'd9, 32'h00000099, 1, 4'h0, 4'd6, 32'h00000066, 0);

        // Write-mode behaviour of douta on a port-A write.
        drive(1, 4'hF, 4'd7, 32'h00000005, 0, 4'h0, 4'd0, 32'd0, 0);
        drive(1, 4'h0, 4'd5, 32'h12345678, 0, 4'h0, 4'd0, 32'd0, 0);
        drive(1, 4'hF, 4'd7, 32'h00000009, 0, 4'h0, 4'd0, 32'd0, 0);
        repeat (3) tick();
        check("NO_CHANGE douta after write", douta_s[0], 32'h12345678);
        check("READ_FIRST douta after write", douta_s[1], 32'h00000005);
        check("WRITE_FIRST douta after write", douta_s[2], 32'h00000009);
        drive(1, 4'h0, 4'd7, 32'h00000009, 0, 4'h0, 4'd0, 32'd0, 0);

        // Reset with a read in flight: nothing may come out.
        drive(1, 4'h0, 4'd5, 32'h12345678, 0, 4'h0, 4'd0, 32'd0, 0);
        rst_n   = 1'b0;
        ready_m = 1'b0;
        flush();
        #1;
        check_reset("inflight");
        tick();
        rst_n = 1'b1;

        // Reset again once the clear has reached address 8; it restarts.
        repeat (8) tick();
        for (int d = 0; d < ND; d++) check($sformatf("dut%0d busy mid-clear", d), 32'(busy_s[d]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midclear");
        tick();
        rst_n = 1'b1;
        clear_phase(1'b1);
        ready_m = 1'b1;
        drive(1, 4'h0, 4'd0, 32'd0, 1, 4'h0, 4'd1, 32'd0, 0);
        drive(1, 4'h0, 4'd5, 32'd0, 1, 4'h0, 4'd3, 32'd0, 0);
        drive(1, 4'h0, 4'd7, 32'd0, 1, 4'h0, 4'd15, 32'd0, 0);
        repeat (4) tick();

        for (int d = 0; d < ND; d++) begin
            check($sformatf("dut%0d douta pending", d), qa[d].size(), 32'd0);
            check($sformatf("dut%0d doutb pending", d), qb[d].size(), 32'd0);
            check($sformatf("dut%0d collision pending", d), qc[d].size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/tdp_ram_be.md
TDP_RAM_BE -- requirements
Module: tdp_ram_be

Interface
REQ-001 Params SHALL be: NUM_COL, default 4, byte columns per word.
REQ-002 COL_W, default 8, bits per column; DATA_W = NUM_COL*COL_W.
REQ-003 DEPTH, default 1024, words; ADDR_W = clog2(DEPTH).
REQ-004 RD_LATENCY, default 1, allowed values 1 or 2.
REQ-005 WRITE_MODE, default NO_CHANGE; allowed NO_CHANGE, READ_FIRST, WRITE_FIRST.
REQ-006 CLEAR_ON_RESET, default 1; when 1, memory is zero-filled after reset.
REQ-007 Ports SHALL be: clka  in  1  single clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 ena/enb  in  1 each  port access request.
REQ-010 wea/web  in  NUM_COL each  per-column write enable; all-zero = read.
REQ-011 addra/addrb  in  ADDR_W each  word address.
REQ-012 dina/dinb  in  DATA_W each  write data.
REQ-013 douta/doutb  out  DATA_W each  read data.
REQ-014 douta_vld/doutb_vld  out  1 each  read data valid, one-cycle pulse.
REQ-015 clr_busy  out  1  zero-fill in progress.
REQ-016 collision  out  1  one-cycle pulse on same-address conflict.

Function
REQ-017 Port access accepted SHALL = en & ~clr_busy; requests during clr_busy are dropped silently with no memory or output change.
REQ-018 Accepted write SHALL update only columns c with we[c]=1; other columns are unchanged.
REQ-019 Accepted read (we=0) SHALL drive dout with mem[addr] and pulse dout_vld exactly RD_LATENCY cycles after the accept edge; back-to-back reads give one result per cycle.
REQ-020 Accepted write SHALL never pulse dout_vld; dout SHALL hold its value (NO_CHANGE), load the pre-write word (READ_FIRST), or load the merged post-write word (WRITE_FIRST), with the same latency as a read.
REQ-021 Collision SHALL = both accepted, addra==addrb, and at least one port writing; collision pulses on the same cycle the colliding data appears on dout (RD_LATENCY after accept).
REQ-022 On write/write collision: columns written by A take A data, columns written only by B take B data.
REQ-023 On read/write collision: the reading port SHALL return the pre-write word.
REQ-024 FSM states SHALL be CLEAR and READY; after rst_n deasserts, enter CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-025 CLEAR SHALL write zero to address 0..DEPTH-1, one word per cycle, holding clr_busy=1, then go to READY; the sequence takes DEPTH cycles.
REQ-026 A read of an address in the same cycle clr_busy falls SHALL return zero.
REQ-027 Address counter SHALL not wrap.
REQ-028 Pipeline stages SHALL advance every cycle, with no back-pressure.

Reset
REQ-029 Under rst_n=0: dout=0, dout_vld=0, collision=0, pipeline flushed, FSM in CLEAR or READY per REQ-024, clr_busy = CLEAR_ON_RESET.
REQ-030 Reset asserted mid-CLEAR or mid-read SHALL abort the operation; in-flight reads are discarded and the clear restarts from address 0.
REQ-031 Memory contents SHALL NOT be reset by rst_n except via the CLEAR sequence.

Structure
REQ-032 Package tdp_ram_pkg SHALL hold: the WRITE_MODE encodings, the FSM state type, and a clog2 function.
REQ-033 Sub-module tdp_ram_outstage SHALL implement the per-port latency/valid pipeline; it is instantiated twice.

Verification
REQ-034 Clear: reset release, DEPTH=16 -> clr_busy high 16 cycles; then reading all addresses returns 0 with vld pulses.
REQ-035 Byte write: A writes 0xAABBCCDD to addr 5, then A writes we=4'b0010 with din 0x00001100 -> B read of addr 5 = 0xAABB11DD.
REQ-036 Latency: RD_LATENCY=2, reads on cycles 0,1,2 -> vld on cycles 2,3,4 with matching data.
REQ-037 Collision: A writes we=4'b1111 din 0x11111111 and B writes we=4'b0011 din 0x22222222, both to addr 3 -> mem=0x11111111, collision pulses once.
REQ-038 Modes: addr 7 holds 0x5, A writes 0x9 -> douta=0x5 (READ_FIRST), 0x9 (WRITE_FIRST), unchanged (NO_CHANGE); douta_vld stays 0 in all three modes.
REQ-039 Reset: rst_n pulsed low at clear address 8 -> clear restarts at 0, taking DEPTH more cycles.
